ysyx_25060170_wbu: RTL and testbench

YSYX_25060170_WBU -- requirements
Module: ysyx_25060170_WBU

---
 rtl/ysyx_25060170_wbu_pkg.sv | 39 +++
 rtl/ysyx_25060170_wbu_loadext.sv | 41 ++++
 rtl/ysyx_25060170_wbu.sv | 136 +++++++++++++
 tb/tb_ysyx_25060170_wbu.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25060170_wbu_pkg.sv
// ============================================================================
// Module   : ysyx_25060170_wbu_pkg
// Brief    : Shared types and constants for the writeback unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ysyx_25060170_wbu_pkg;

  localparam int          REG_IDX_W = 5;
  localparam logic [1:0]  RESP_OK   = 2'b00;

  localparam logic [2:0]  F3_LB  = 3'b000;
  localparam logic [2:0]  F3_LH  = 3'b001;
  localparam logic [2:0]  F3_LW  = 3'b010;
  localparam logic [2:0]  F3_LBU = 3'b100;
  localparam logic [2:0]  F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_COMMIT   = 2'd2
  } wbu_state_e;

  // Halfwords need an even address, words a 4-byte aligned address.
  function automatic logic load_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if ((funct3 == F3_LH) || (funct3 == F3_LHU))
      mis = addr_lo[0];
    else if (funct3 == F3_LW)
      mis = (addr_lo != 2'b00);
    return mis;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_25060170_wbu_loadext.sv
// ============================================================================
// Module   : ysyx_25060170_LoadExt
// Brief    : Combinational byte/halfword/word extraction from an aligned word.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ysyx_25060170_LoadExt
  import ysyx_25060170_wbu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] data,
  output logic            bad_funct3
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = rdata[{addr_lo, 3'b000} +: 8];
  assign w_half = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    data       = rdata;
    bad_funct3 = 1'b0;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LH:   data = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LW:   data = rdata;
      F3_LBU:  data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, w_half};
      default: bad_funct3 = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_25060170_wbu.sv
// ============================================================================
// Module   : ysyx_25060170_wbu
// Brief    : Writeback unit: commits ALU results or extracted load data to GPRs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ysyx_25060170_wbu
  import ysyx_25060170_wbu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_IDX_W-1:0] in_rd,
  input  logic                 in_rd_wen,
  input  logic                 in_is_load,
  input  logic [2:0]           in_funct3,
  input  logic [1:0]           in_addr_lo,
  input  logic [XLEN-1:0]      in_alu_res,
  input  logic                 mem_rvalid,
  output logic                 mem_rready,
  input  logic [XLEN-1:0]      mem_rdata,
  input  logic [1:0]           mem_rresp,
  output logic                 gpr_we,
  output logic [REG_IDX_W-1:0] gpr_writer,
  output logic [XLEN-1:0]      gpr_wd,
  output logic                 wb_done,
  output logic                 wb_fault
);

  wbu_state_e             r_state;
  wbu_state_e             w_state_next;

  logic [REG_IDX_W-1:0]   r_rd;
  logic                   r_rd_wen;
  logic [2:0]             r_funct3;
  logic [1:0]             r_addr_lo;
  logic [XLEN-1:0]        r_wd;
  logic                   r_fault;

  logic [2:0]             w_ext_funct3;
  logic [1:0]             w_ext_addr_lo;
  logic [XLEN-1:0]        w_ext_data;
  logic                   w_bad_funct3;
  logic                   w_accept_fault;

  // The extractor validates the incoming funct3 while idle and decodes the
  // latched access while waiting for memory.
  assign w_ext_funct3  = (r_state == S_IDLE) ? in_funct3  : r_funct3;
  assign w_ext_addr_lo = (r_state == S_IDLE) ? in_addr_lo : r_addr_lo;

  ysyx_25060170_LoadExt #(
    .XLEN       (XLEN)
  ) u_load_ext (
    .rdata      (mem_rdata),
    .funct3     (w_ext_funct3),
    .addr_lo    (w_ext_addr_lo),
    .data       (w_ext_data),
    .bad_funct3 (w_bad_funct3)
  );

  assign w_accept_fault = in_is_load &
                          (w_bad_funct3 | load_misaligned(in_funct3, in_addr_lo));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    mem_rready   = 1'b0;
    wb_done      = 1'b0;
    wb_fault     = 1'b0;
    gpr_we       = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          w_state_next = (in_is_load && !w_accept_fault) ? S_WAIT_MEM : S_COMMIT;
      end
      S_WAIT_MEM: begin
        mem_rready = 1'b1;
        if (mem_rvalid) w_state_next = S_COMMIT;
      end
      S_COMMIT: begin
        wb_done      = 1'b1;
        wb_fault     = r_fault;
        gpr_we       = r_rd_wen && (r_rd != '0) && !r_fault;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd      <= '0;
      r_rd_wen  <= 1'b0;
      r_funct3  <= '0;
      r_addr_lo <= '0;
      r_wd      <= '0;
      r_fault   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_rd      <= in_rd;
            r_rd_wen  <= in_rd_wen;
            r_funct3  <= in_funct3;
            r_addr_lo <= in_addr_lo;
            r_wd      <= in_alu_res;
            r_fault   <= w_accept_fault;
          end
        end
        S_WAIT_MEM: begin
          if (mem_rvalid) begin
            r_wd    <= w_ext_data;
            r_fault <= (mem_rresp != RESP_OK);
          end
        end
        default: ;
      endcase
    end
  end

  assign gpr_writer = r_rd;
  assign gpr_wd     = r_wd;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25060170_wbu.sv
// ============================================================================
// Module   : tb_ysyx_25060170_wbu
// Brief    : Directed scoreboard bench for the writeback unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_25060170_wbu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = '0;
  logic        in_rd_wen = 1'b0;
  logic        in_is_load = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [1:0]  in_addr_lo = '0;
  logic [31:0] in_alu_res = '0;
  logic        mem_rvalid = 1'b0;
  logic        mem_rready;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  mem_rresp = '0;
  logic        gpr_we;
  logic [4:0]  gpr_writer;
  logic [31:0] gpr_wd;
  logic        wb_done;
  logic        wb_fault;

  typedef struct packed {
    logic        we;
    logic [4:0]  writer;
    logic [31:0] wd;
    logic        fault;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   fails   = 0;
  logic mon_en  = 1'b0;

  always #5 clk = ~clk;

  ysyx_25060170_wbu #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rd      (in_rd),
    .in_rd_wen  (in_rd_wen),
    .in_is_load (in_is_load),
    .in_funct3  (in_funct3),
    .in_addr_lo (in_addr_lo),
    .in_alu_res (in_alu_res),
    .mem_rvalid (mem_rvalid),
    .mem_rready (mem_rready),
    .mem_rdata  (mem_rdata),
    .mem_rresp  (mem_rresp),
    .gpr_we     (gpr_we),
    .gpr_writer (gpr_writer),
    .gpr_wd     (gpr_wd),
    .wb_done    (wb_done),
    .wb_fault   (wb_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Commit monitor: every wb_done pops one expected writeback.
  always @(negedge clk) begin
    if (mon_en) begin
      if (wb_done) begin
        vectors++;
        assert (q.size() != 0) else begin
          fails++;
          $error("FAIL unexpected_commit observed=%0d expected=%0d", 1, 0);
        end
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          chk("commit_we",     {31'b0, gpr_we},     {31'b0, e.we});
          chk("commit_writer", {27'b0, gpr_writer}, {27'b0, e.writer});
          chk("commit_wd",     gpr_wd,              e.wd);
          chk("commit_fault",  {31'b0, wb_fault},   {31'b0, e.fault});
        end
      end else begin
        chk("idle_we",    {31'b0, gpr_we},   32'd0);
        chk("idle_fault", {31'b0, wb_fault}, 32'd0);
      end
    end
  end

  // Called at a negedge in IDLE; returns at the following negedge.
  task automatic issue(input logic [4:0] rd, input logic wen, input logic ld,
                       input logic [2:0] f3, input logic [1:0] alo, input logic [31:0] alu);
    chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
    in_valid   = 1'b1;
    in_rd      = rd;
    in_rd_wen  = wen;
    in_is_load = ld;
    in_funct3  = f3;
    in_addr_lo = alo;
    in_alu_res = alu;
    @(negedge clk);
    in_valid   = 1'b0;
  endtask

  // Called at a negedge in WAIT_MEM; returns at a negedge back in IDLE.
  task automatic respond(input logic [31:0] data, input logic [1:0] resp, input int stall);
    for (int i = 0; i < stall; i++) begin
      chk("in_ready_wait",   {31'b0, in_ready},   32'd0);
      chk("mem_rready_wait", {31'b0, mem_rready}, 32'd1);
      @(negedge clk);
    end
    chk("mem_rready_resp", {31'b0, mem_rready}, 32'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    mem_rresp  = resp;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rresp  = 2'd0;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_gpr_we",     {31'b0, gpr_we},     32'd0);
    chk("rst_wb_done",    {31'b0, wb_done},    32'd0);
    chk("rst_wb_fault",   {31'b0, wb_fault},   32'd0);
    chk("rst_mem_rready", {31'b0, mem_rready}, 32'd0);
    chk("rst_writer",     {27'b0, gpr_writer}, 32'd0);
    chk("rst_wd",         gpr_wd,              32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    mon_en = 1'b1;

    // ALU writeback, then in_ready one cycle after commit
    q.push_back('{we: 1'b1, writer: 5'd5, wd: 32'h1234_5678, fault: 1'b0});
    issue(5'd5, 1'b1, 1'b0, 3'b000, 2'd0, 32'h1234_5678);
    chk("alu_done_n1", {31'b0, wb_done}, 32'd1);
    @(negedge clk);
    chk("alu_ready_n2", {31'b0, in_ready}, 32'd1);

    // x0 suppression and wen=0 (non-load ignores odd funct3/addr)
    q.push_back('{we: 1'b0, writer: 5'd0, wd: 32'h0000_DEAD, fault: 1'b0});
    issue(5'd0, 1'b1, 1'b0, 3'b111, 2'd3, 32'h0000_DEAD);
    @(negedge clk);
    q.push_back('{we: 1'b0, writer: 5'd3, wd: 32'hA5A5_0001, fault: 1'b0});
    issue(5'd3, 1'b0, 1'b0, 3'b010, 2'd1, 32'hA5A5_0001);
    @(negedge clk);

    // lb sign extension with a 3-cycle memory stall
    q.push_back('{we: 1'b1, writer: 5'd7, wd: 32'hFFFF_FF80, fault: 1'b0});
    issue(5'd7, 1'b1, 1'b1, 3'b000, 2'd3, 32'h11);
    respond(32'h80FF_0000, 2'd0, 3);

    // lhu, lh, lbu, lw extraction
    q.push_back('{we: 1'b1, writer: 5'd8, wd: 32'h0000_BEEF, fault: 1'b0});
    issue(5'd8, 1'b1, 1'b1, 3'b101, 2'd2, 32'h11);
    respond(32'hBEEF_1234, 2'd0, 0);
    q.push_back('{we: 1'b1, writer: 5'd9, wd: 32'hFFFF_8001, fault: 1'b0});
    issue(5'd9, 1'b1, 1'b1, 3'b001, 2'd0, 32'h11);
    respond(32'h1234_8001, 2'd0, 1);
    q.push_back('{we: 1'b1, writer: 5'd10, wd: 32'h0000_00A5, fault: 1'b0});
    issue(5'd10, 1'b1, 1'b1, 3'b100, 2'd1, 32'h11);
    respond(32'h0000_A500, 2'd0, 0);
    q.push_back('{we: 1'b1, writer: 5'd11, wd: 32'hCAFE_F00D, fault: 1'b0});
    issue(5'd11, 1'b1, 1'b1, 3'b010, 2'd0, 32'h11);
    respond(32'hCAFE_F00D, 2'd0, 0);

    // Misaligned lw: fault at accept, no memory handshake
    q.push_back('{we: 1'b0, writer: 5'd12, wd: 32'h0000_0022, fault: 1'b1});
    issue(5'd12, 1'b1, 1'b1, 3'b010, 2'd1, 32'h22);
    chk("mis_lw_no_rready", {31'b0, mem_rready}, 32'd0);
    @(negedge clk);

    // Misaligned lh and unsupported funct3
    q.push_back('{we: 1'b0, writer: 5'd13, wd: 32'h0000_0033, fault: 1'b1});
    issue(5'd13, 1'b1, 1'b1, 3'b001, 2'd1, 32'h33);
    chk("mis_lh_no_rready", {31'b0, mem_rready}, 32'd0);
    @(negedge clk);
    q.push_back('{we: 1'b0, writer: 5'd14, wd: 32'h0000_0044, fault: 1'b1});
    issue(5'd14, 1'b1, 1'b1, 3'b011, 2'd0, 32'h44);
    chk("bad_f3_no_rready", {31'b0, mem_rready}, 32'd0);
    @(negedge clk);

    // Bus error response on lw
    q.push_back('{we: 1'b0, writer: 5'd15, wd: 32'h5555_5555, fault: 1'b1});
    issue(5'd15, 1'b1, 1'b1, 3'b010, 2'd0, 32'h55);
    respond(32'h5555_5555, 2'd2, 0);

    // Reset while waiting for memory discards the load
    issue(5'd16, 1'b1, 1'b1, 3'b000, 2'd0, 32'h66);
    chk("pre_rst_rready", {31'b0, mem_rready}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("wrst_we",     {31'b0, gpr_we},     32'd0);
    chk("wrst_rready", {31'b0, mem_rready}, 32'd0);
    chk("wrst_writer", {27'b0, gpr_writer}, 32'd0);
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h7777_7777;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stray_rvalid_done",   {31'b0, wb_done},    32'd0);
      chk("stray_rvalid_rready", {31'b0, mem_rready}, 32'd0);
      chk("stray_rvalid_ready",  {31'b0, in_ready},   32'd1);
    end
    mem_rvalid = 1'b0;

    // Normal operation resumes
    q.push_back('{we: 1'b1, writer: 5'd1, wd: 32'h0BAD_F00D, fault: 1'b0});
    issue(5'd1, 1'b1, 1'b0, 3'b000, 2'd0, 32'h0BAD_F00D);
    repeat (3) @(negedge clk);

    chk("scoreboard_empty", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

`default_nettype wire
